// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voice slots per event, retriggers, allocates or steals.
// Define VOICE_STEAL_EN to steal the oldest voice when every slot is busy.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EVT_VALID,
    output logic                    EVT_READY,
    input  logic                    EVT_ON,
    input  logic [6:0]              EVT_NOTE,
    input  logic [6:0]              EVT_VEL,
    input  logic                    ALL_OFF,
    output logic [8*NUM_VOICES-1:0] VOICE_KEY,
    output logic [NUM_VOICES-1:0]   VOICE_ACTIVE,
    output logic [NUM_VOICES-1:0]   VOICE_TRIG,
    output logic                    STEAL
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic              ev_on;
    logic [6:0]        ev_note;

    logic              m_hit;
    logic [IW-1:0]     m_idx;
    logic              f_hit;
    logic [IW-1:0]     f_idx;
`ifdef VOICE_STEAL_EN
    logic              o_hit;
    logic [IW-1:0]     o_idx;
    logic [AGE_W-1:0]  o_age;
`endif

    logic [6:0]        key [NUM_VOICES];
    logic [AGE_W-1:0]  age [NUM_VOICES];
    logic [NUM_VOICES-1:0] active;
    logic [NUM_VOICES-1:0] trig;
    logic              steal_q;

    logic              in_range;
    logic              cur_hit;
    logic              act_on;
    logic              act_new;
    logic              act_steal;
    logic              act_off;
    logic [IW-1:0]     sel;

    assign EVT_READY    = (state == IDLE);
    assign VOICE_ACTIVE = active;
    assign VOICE_TRIG   = trig;
    assign STEAL        = steal_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key
        assign VOICE_KEY[8*g +: 8] = {1'b0, key[g]};
    end

    // The synth frequency table only covers 12..119.
    assign in_range = (ev_note >= 7'd12) && (ev_note <= 7'd119);
    assign cur_hit  = active[idx] && (key[idx] == ev_note);

    always_comb begin
        sel       = m_idx;
        act_on    = 1'b0;
        act_new   = 1'b0;
        act_steal = 1'b0;
        act_off   = 1'b0;
        if (in_range) begin
            if (ev_on) begin
                if (m_hit) begin
                    act_on = 1'b1;
                end else if (f_hit) begin
                    act_on  = 1'b1;
                    act_new = 1'b1;
                    sel     = f_idx;
                end
`ifdef VOICE_STEAL_EN
                else if (o_hit) begin
                    act_on    = 1'b1;
                    act_new   = 1'b1;
                    act_steal = 1'b1;
                    sel       = o_idx;
                end
`endif
            end else if (m_hit) begin
                act_off = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            idx     <= '0;
            ev_on   <= 1'b0;
            ev_note <= '0;
            m_hit   <= 1'b0;
            m_idx   <= '0;
            f_hit   <= 1'b0;
            f_idx   <= '0;
`ifdef VOICE_STEAL_EN
            o_hit   <= 1'b0;
            o_idx   <= '0;
            o_age   <= '0;
`endif
            active  <= '0;
            trig    <= '0;
            steal_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                key[v] <= '0;
                age[v] <= '0;
            end
        end else begin
            trig    <= '0;
            steal_q <= 1'b0;
            if (ALL_OFF) begin
                state  <= IDLE;
                active <= '0;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    key[v] <= '0;
                    age[v] <= '0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (EVT_VALID) begin
                            ev_on   <= EVT_ON && (EVT_VEL != 7'd0);
                            ev_note <= EVT_NOTE;
                            idx     <= '0;
                            m_hit   <= 1'b0;
                            f_hit   <= 1'b0;
`ifdef VOICE_STEAL_EN
                            o_hit   <= 1'b0;
`endif
                            state   <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (cur_hit && !m_hit) begin
                            m_hit <= 1'b1;
                            m_idx <= idx;
                        end
                        if (!active[idx] && !f_hit) begin
                            f_hit <= 1'b1;
                            f_idx <= idx;
                        end
`ifdef VOICE_STEAL_EN
                        if (active[idx] && (!o_hit || age[idx] > o_age)) begin
                            o_hit <= 1'b1;
                            o_idx <= idx;
                            o_age <= age[idx];
                        end
`endif
                        if (idx == LAST) begin
                            state <= COMMIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    COMMIT: begin
                        if (act_on) begin
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (active[v] && IW'(v) != sel && age[v] != '1) begin
                                    age[v] <= age[v] + 1'b1;
                                end
                            end
                            age[sel]  <= '0;
                            trig[sel] <= 1'b1;
                            steal_q   <= act_steal;
                            if (act_new) begin
                                key[sel]    <= ev_note;
                                active[sel] <= 1'b1;
                            end
                        end
                        if (act_off) begin
                            key[sel]    <= '0;
                            active[sel] <= 1'b0;
                            age[sel]    <= '0;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
